seg7_digit_driver: RTL



---
 rtl/seg7_pkg.sv | 29 ++
 rtl/seg7_tick_gen.sv | 54 +++++
 rtl/seg7_digit_driver.sv | 122 ++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment digit driver.
// Segment vectors are ordered g..a (bit 6 = g, bit 0 = a), active-high.
package seg7_pkg;

    typedef enum logic {
        LAMP = 1'b0,
        RUN  = 1'b1
    } seg7_state_e;

    // Field positions inside the PIO byte.
    localparam int unsigned BIT_RAW   = 7;
    localparam int unsigned BIT_BLANK = 6;
    localparam int unsigned BIT_BLINK = 5;
    localparam int unsigned BIT_DP    = 4;

    localparam logic [6:0] SEG_ALL_ON = 7'h7F;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] seg7_decode(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_tick_gen.sv
// Prescaler producing a one-cycle tick every PRESCALE clocks, plus a
// free-running blink phase that toggles every BLINK_TICKS ticks.
module seg7_tick_gen
    import seg7_pkg::*;
#(
    parameter int unsigned PRESCALE    = 50000,
    parameter int unsigned BLINK_TICKS = 500
) (
    input  logic clk,
    input  logic reset,
    output logic tick,
    output logic blink_ph
);

    localparam int unsigned TW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [TW-1:0] TICK_MAX  = TW'(PRESCALE - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_ph_q, blink_ph_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q  <= '0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
        end
    end

    // The phase keeps running regardless of whether any digit is blinking.
    always_comb begin
        tick        = (tick_cnt_q == TICK_MAX);
        tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        if (tick) begin
            if (blink_cnt_q == BLINK_MAX) begin
                blink_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    assign blink_ph = blink_ph_q;

endmodule

// File: rtl/seg7_digit_driver.sv
// Converts a HEX PIO byte into active-low drive for one 7-segment digit.
// Define SEG7_LAMP_TEST_EN to include the power-on all-segments lamp test.
module seg7_digit_driver
    import seg7_pkg::*;
#(
    parameter int unsigned PRESCALE    = 50000,
    parameter int unsigned BLINK_TICKS = 500,
    parameter int unsigned LAMP_TICKS  = 1000,
    parameter int unsigned BRIGHTNESS  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pio_data,
    output logic [6:0] hex_n,
    output logic       dp_n,
    output logic       lamp_busy
);

    localparam logic [4:0] BRIGHT5 = 5'(BRIGHTNESS);

    logic [7:0] pio_q, pio_d;
    logic [3:0] pwm_cnt_q, pwm_cnt_d;
    logic [6:0] hex_n_q, hex_n_d;
    logic       dp_n_q, dp_n_d;
    logic       tick;
    logic       blink_ph;
    logic       pwm_on;
    logic       in_lamp;
    logic [6:0] seg;
    logic       dp;
    logic       suppress;

    seg7_tick_gen #(
        .PRESCALE    (PRESCALE),
        .BLINK_TICKS (BLINK_TICKS)
    ) u_tick_gen (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .blink_ph (blink_ph)
    );

`ifdef SEG7_LAMP_TEST_EN
    localparam int unsigned LW = (LAMP_TICKS > 1) ? $clog2(LAMP_TICKS) : 1;
    localparam logic [LW-1:0] LAMP_MAX = LW'(LAMP_TICKS - 1);

    seg7_state_e   state_q, state_d;
    logic [LW-1:0] lamp_cnt_q, lamp_cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= LAMP;
            lamp_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lamp_cnt_q <= lamp_cnt_d;
        end
    end

    // RUN is never left; only reset brings the lamp test back.
    always_comb begin
        state_d    = state_q;
        lamp_cnt_d = lamp_cnt_q;
        if (state_q == LAMP && tick) begin
            if (lamp_cnt_q == LAMP_MAX) begin
                state_d = RUN;
            end else begin
                lamp_cnt_d = lamp_cnt_q + 1'b1;
            end
        end
    end

    assign in_lamp = (state_q == LAMP);
`else
    // Without the lamp test neither the tick nor the lamp length has a consumer here.
    localparam int unsigned UNUSED_LAMP_TICKS = LAMP_TICKS;
    logic unused_tick;

    assign unused_tick = tick;
    assign in_lamp     = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pio_q     <= '0;
            pwm_cnt_q <= '0;
            hex_n_q   <= 7'h7F;
            dp_n_q    <= 1'b1;
        end else begin
            pio_q     <= pio_d;
            pwm_cnt_q <= pwm_cnt_d;
            hex_n_q   <= hex_n_d;
            dp_n_q    <= dp_n_d;
        end
    end

    // Blink and blank only apply to decoded digits outside the lamp test.
    always_comb begin
        pio_d     = pio_data;
        pwm_cnt_d = pwm_cnt_q + 4'd1;
        pwm_on    = ({1'b0, pwm_cnt_q} < BRIGHT5);
        seg       = '0;
        dp        = 1'b0;
        suppress  = pio_q[BIT_BLANK] || (pio_q[BIT_BLINK] && blink_ph);
        if (in_lamp) begin
            seg = SEG_ALL_ON;
            dp  = 1'b1;
        end else if (pio_q[BIT_RAW]) begin
            seg = pio_q[6:0];
        end else if (!suppress) begin
            seg = seg7_decode(pio_q[3:0]);
            dp  = pio_q[BIT_DP];
        end
        hex_n_d = ~(seg & {7{pwm_on}});
        dp_n_d  = ~(dp & pwm_on);
    end

    assign hex_n     = hex_n_q;
    assign dp_n      = dp_n_q;
    assign lamp_busy = in_lamp;

endmodule
